// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared constants, the write-back entry type and the address
//               match helper for the register-file write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;

  // x0 is hard-wired to zero; it is never written and never reported as a hazard
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_entry_t;

  // True when a pending destination collides with a real (non-x0) read address
  function automatic logic addr_match(input logic [REG_ADDR_W-1:0] rd,
                                      input logic [REG_ADDR_W-1:0] a);
    return (a != REG_ZERO) && (rd == a);
  endfunction

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_if
// Description : Bundle of ALU result, load result, hazard-check and regfile
//               write-port signals around the write arbiter. The forwarding
//               outputs exist only when WB_FORWARD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) ();
  import wb_pkg::*;

  localparam int c_OCC_W = $clog2(DEPTH + 1);

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic [XLEN-1:0]       ld_data;
  logic [REG_ADDR_W-1:0] chk_a1;
  logic [REG_ADDR_W-1:0] chk_a2;
  logic                  chk_hit1;
  logic                  chk_hit2;
  logic                  WE3;
  logic [REG_ADDR_W-1:0] A3;
  logic [XLEN-1:0]       WD3;
  logic [c_OCC_W-1:0]    occupancy;
`ifdef WB_FORWARD_EN
  logic                  fwd_valid1;
  logic                  fwd_valid2;
  logic [XLEN-1:0]       fwd_data1;
  logic [XLEN-1:0]       fwd_data2;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, chk_a1, chk_a2,
    output ld_ready, chk_hit1, chk_hit2, WE3, A3, WD3, occupancy,
    output fwd_valid1, fwd_valid2, fwd_data1, fwd_data2
  );

  // Pipeline / producer side
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, chk_a1, chk_a2,
    input  ld_ready, chk_hit1, chk_hit2, WE3, A3, WD3, occupancy,
    input  fwd_valid1, fwd_valid2, fwd_data1, fwd_data2
  );
`else
  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, chk_a1, chk_a2,
    output ld_ready, chk_hit1, chk_hit2, WE3, A3, WD3, occupancy
  );

  // Pipeline / producer side
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, chk_a1, chk_a2,
    input  ld_ready, chk_hit1, chk_hit2, WE3, A3, WD3, occupancy
  );
`endif

endinterface : wb_arbiter_if
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous {rd, data} FIFO for buffered load results. Exposes
//               its storage and a per-entry valid mask so the owner can build
//               hazard comparators. With WB_FORWARD_EN the read pointer is also
//               exported so the owner can order matches by age.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  wire logic                             clk,
  input  wire logic                             reset,
  input  wire logic                             i_push,
  input  wire logic [REG_ADDR_W-1:0]            i_push_rd,
  input  wire logic [XLEN-1:0]                  i_push_data,
  input  wire logic                             i_pop,
  output logic                                  o_full,
  output logic                                  o_empty,
  output logic [$clog2(DEPTH+1)-1:0]            o_count,
  output logic [REG_ADDR_W-1:0]                 o_head_rd,
  output logic [XLEN-1:0]                       o_head_data,
  output logic [REG_ADDR_W-1:0]                 o_ent_rd   [DEPTH],
  output logic [XLEN-1:0]                       o_ent_data [DEPTH],
  output logic [DEPTH-1:0]                      o_valid
`ifdef WB_FORWARD_EN
  ,
  output logic [$clog2(DEPTH)-1:0]              o_rd_ptr
`endif
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic [REG_ADDR_W-1:0] r_rd   [DEPTH];
  logic [XLEN-1:0]       r_data [DEPTH];
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_CNT_W-1:0]    r_count;

  logic w_push;
  logic w_pop;

  // Guard against overflow/underflow regardless of what the owner requests
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  // Entry storage; contents are qualified by the valid mask so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wr_ptr]   <= i_push_rd;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full      = (r_count == c_CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_head_rd   = r_rd[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];
  assign o_ent_rd    = r_rd;
  assign o_ent_data  = r_data;
`ifdef WB_FORWARD_EN
  assign o_rd_ptr    = r_rd_ptr;
`endif

  // An entry is live when its distance from the read pointer is below the count
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [c_PTR_W-1:0] w_age;
    assign w_age      = c_PTR_W'(i) - r_rd_ptr;
    assign o_valid[i] = (c_CNT_W'(w_age) < r_count);
  end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Regfile write-port arbiter. ALU results win the port, buffered
//               loads drain oldest first, and a load arriving to an empty
//               buffer is written with zero latency. Reports pending-load
//               hazards on the two read addresses. Optional feature macro:
//               WB_FORWARD_EN adds per-read-port forwarding outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  wire logic   clk,
  input  wire logic   reset,
  wb_arbiter_if.slave bus
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic                  w_full;
  logic                  w_empty;
  logic [c_CNT_W-1:0]    w_count;
  logic [REG_ADDR_W-1:0] w_head_rd;
  logic [XLEN-1:0]       w_head_data;
  logic [REG_ADDR_W-1:0] w_ent_rd   [DEPTH];
  logic [XLEN-1:0]       w_ent_data [DEPTH];
  logic [DEPTH-1:0]      w_valid;

  logic                  w_alu_wr;
  logic                  w_ld_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_direct;
  logic                  w_we3;
  logic [REG_ADDR_W-1:0] w_a3;
  logic [XLEN-1:0]       w_wd3;
  logic                  w_hit1;
  logic                  w_hit2;

`ifdef WB_FORWARD_EN
  logic [c_PTR_W-1:0]    w_rd_ptr;
`endif

  wb_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_rd   (bus.ld_rd),
    .i_push_data (bus.ld_data),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_ent_rd    (w_ent_rd),
    .o_ent_data  (w_ent_data),
    .o_valid     (w_valid)
`ifdef WB_FORWARD_EN
    ,
    .o_rd_ptr    (w_rd_ptr)
`endif
  );

  // Readiness looks at the registered count only: a full buffer refuses even
  // when it is being drained in the same cycle
  assign w_ld_ready = ~w_full & ~reset;
  assign w_alu_wr   = bus.alu_valid & (bus.alu_rd != REG_ZERO);

  // Port owner: ALU, then buffer head, then a load straight through an empty buffer
  always_comb begin
    w_we3    = 1'b0;
    w_a3     = '0;
    w_wd3    = '0;
    w_pop    = 1'b0;
    w_direct = 1'b0;
    if (!reset) begin
      if (w_alu_wr) begin
        w_we3 = 1'b1;
        w_a3  = bus.alu_rd;
        w_wd3 = bus.alu_data;
      end else if (!w_empty) begin
        w_we3 = 1'b1;
        w_a3  = w_head_rd;
        w_wd3 = w_head_data;
        w_pop = 1'b1;
      end else if (bus.ld_valid && (bus.ld_rd != REG_ZERO)) begin
        w_we3    = 1'b1;
        w_a3     = bus.ld_rd;
        w_wd3    = bus.ld_data;
        w_direct = 1'b1;
      end
    end
  end

  // Accepted loads that did not go straight to the port are buffered; x0 loads vanish
  assign w_push = bus.ld_valid & w_ld_ready & ~w_direct & (bus.ld_rd != REG_ZERO);

  // Hazard flags: any live buffered load targeting a read address
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && addr_match(w_ent_rd[i], bus.chk_a1)) w_hit1 = 1'b1;
      if (w_valid[i] && addr_match(w_ent_rd[i], bus.chk_a2)) w_hit2 = 1'b1;
    end
    if (reset) begin
      w_hit1 = 1'b0;
      w_hit2 = 1'b0;
    end
  end

  assign bus.WE3       = w_we3;
  assign bus.A3        = w_a3;
  assign bus.WD3       = w_wd3;
  assign bus.ld_ready  = w_ld_ready;
  assign bus.chk_hit1  = w_hit1;
  assign bus.chk_hit2  = w_hit2;
  assign bus.occupancy = w_count;

`ifdef WB_FORWARD_EN
  logic [REG_ADDR_W-1:0] w_chk   [2];
  logic                  w_fwd_v [2];
  logic [XLEN-1:0]       w_fwd_d [2];

  assign w_chk[0] = bus.chk_a1;
  assign w_chk[1] = bus.chk_a2;

  for (genvar p = 0; p < 2; p++) begin : g_fwd
    logic [c_PTR_W-1:0] w_idx [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_idx
      assign w_idx[k] = w_rd_ptr + c_PTR_W'(k);
    end

    // Walk oldest to youngest so the youngest match wins; the write on the port this cycle overrides
    always_comb begin
      w_fwd_v[p] = 1'b0;
      w_fwd_d[p] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        if ((c_CNT_W'(k) < w_count) && addr_match(w_ent_rd[w_idx[k]], w_chk[p])) begin
          w_fwd_v[p] = 1'b1;
          w_fwd_d[p] = w_ent_data[w_idx[k]];
        end
      end
      if (w_we3 && addr_match(w_a3, w_chk[p])) begin
        w_fwd_v[p] = 1'b1;
        w_fwd_d[p] = w_wd3;
      end
      if (reset) begin
        w_fwd_v[p] = 1'b0;
        w_fwd_d[p] = '0;
      end
    end
  end

  assign bus.fwd_valid1 = w_fwd_v[0];
  assign bus.fwd_valid2 = w_fwd_v[1];
  assign bus.fwd_data1  = w_fwd_d[0];
  assign bus.fwd_data2  = w_fwd_d[1];
`endif

endmodule : wb_arbiter
`default_nettype wire
